memory_cycle: RTL and testbench
===============================

# memory_cycle

Pipeline MEM stage: takes the EX/MEM bundle, performs load/store to data memory over a req/ack handshake, sign/zero-extends load data, and registers the MEM/WB bundle consumed by `writeback_cycle`. It stalls the front of the pipeline while a data-memory access is outstanding. On a stall it inserts a bubble into MEM/WB, so writeback never commits twice.

## Interface
Parameters: none.

Ports:
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ALUResult_M` in 32: effective address / ALU result.
- `WriteData_M` in 32: store data (rs2).
- `PCPlus4_M` in 32: PC+4.
- `RD_M` in 5: destination register.
- `funct3_M` in 3: access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `mem_rden_M` in 1: load.
- `mem_wren_M` in 1: store.
- `rd_wren_M` in 1: register write enable.
- `wb_sel_M` in 2: writeback select, passed through.
- `insn_vld_M` in 1: EX/MEM slot holds a valid instruction.
- `dmem_req` out 1: access request.
- `dmem_we` out 1: write strobe.
- `dmem_addr` out 32: word-aligned address, `{ALUResult_M[31:2],2'b00}`.
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_rdata` in 32: read data, valid with `dmem_ack`.
- `dmem_ack` in 1: access complete.
- `stall_M` out 1: hold IF..EX/MEM this cycle.
- `misalign_M` out 1: misaligned access flagged (see Configuration).
- MEM/WB outputs, all registered: `ReadData_W` out 32, `ALUResult_W` out 32, `PCPlus4_W` out 32, `RD_W` out 5, `rd_wren_W` out 1, `wb_sel_W` out 2, `insn_vld_W` out 1.

## Operation
- Memory op: `mem_op = insn_vld_M & (mem_rden_M | mem_wren_M) & ~misalign_M`.
- FSM has two states.
  - `IDLE`: if `mem_op`, drive `dmem_req=1`. If `dmem_ack` the same cycle, the access completes and the FSM stays in IDLE. Otherwise go to BUSY.
  - `BUSY`: hold `dmem_req=1`. On `dmem_ack`, complete and return to IDLE.
- While requesting, `dmem_addr`/`dmem_be`/`dmem_wdata`/`dmem_we` are combinational from EX/MEM inputs. Upstream holds them stable during `stall_M`.
- `stall_M = mem_op & ~dmem_ack`.
- Byte enables:
  - B: `4'b0001 << addr[1:0]`.
  - H: `4'b0011 << {addr[1],1'b0}`.
  - W: `4'b1111`.
- `dmem_wdata`: byte replicated ×4, half replicated ×2, or the full word.
- Load extract: select byte/half from `dmem_rdata` using `addr[1:0]`. Sign-extend for 000/001, zero-extend for 100/101.
- `funct3` values 011/110/111 on a memory op are treated as W.
- MEM/WB update each cycle:
  - If `stall_M`: load a bubble (`insn_vld_W=0`, `rd_wren_W=0`; other fields don't care, hold previous).
  - Else: load the EX/MEM bundle. `ReadData_W` gets the extended load data, or 0 for non-loads.
- Non-memory instructions pass through in one cycle without touching `dmem_*`.

## Timing
- Reset:
  - FSM goes to IDLE.
  - All MEM/WB outputs are 0.
  - `dmem_req`, `dmem_we`, `dmem_be`, and `stall_M` are 0.
- Reset mid-access (BUSY): the request drops the next cycle and any late `dmem_ack` in IDLE with no `mem_op` is ignored.
- Latency, EX/MEM to MEM/WB valid:
  - 1 cycle for non-memory instructions, or when `dmem_ack` arrives in the request cycle.
  - 1+N cycles when ack arrives N cycles after the first request cycle.
- `dmem_ack` is sampled only while `dmem_req=1`.
- Back-to-back memory ops: the second request starts the cycle after the first completes. No idle cycle is inserted.
- `insn_vld_M=0` generates no request and no stall, regardless of the other inputs.

## Configuration
- `MEM_MISALIGN_CHK_EN` defined:
  - `misalign_M = insn_vld_M & (mem_rden_M|mem_wren_M) & ((H & addr[0]) | (W & addr[1:0]!=0))`.
  - A flagged instruction issues no request and no stall, and enters MEM/WB with `insn_vld_W=0`, `rd_wren_W=0`.
- Not defined: `misalign_M` is tied to 0 and accesses use the truncated aligned address with the computed byte enables.

## Test plan
- Reset with `dmem_ack=1` held → all MEM/WB outputs 0, `dmem_req=0`, `stall_M=0`.
- ALU op, `ALUResult_M=0x1234`, `RD_M=5`, `rd_wren_M=1` → next cycle `ALUResult_W=0x1234`, `RD_W=5`, `insn_vld_W=1`, no `dmem_req`.
- LB at address 0x103, memory returns 0x80FF_0000 with ack after 3 cycles:
  - `dmem_addr=0x100`, `dmem_be=4'b1000`.
  - `stall_M=1` for 3 cycles, with bubbles in MEM/WB.
  - Then `ReadData_W=0xFFFF_FF80`.
  - The same access as LBU gives `0x0000_0080`.
- SH at 0x202 with `WriteData_M=0xAAAA_BEEF`, same-cycle ack → `dmem_be=4'b1100`, `dmem_wdata=0xBEEF_BEEF`, `dmem_we=1`, no stall.
- `rst` asserted in BUSY → next cycle `dmem_req=0`, `stall_M=0`, FSM IDLE. A subsequent LW to 0x10 with ack returns the word unchanged.
- With `MEM_MISALIGN_CHK_EN`, LW at 0x102 → `misalign_M=1`, no request, `insn_vld_W=0`. Without the macro → request to 0x100, `be=4'b1111`.

Source files
------------

// File: rtl/memory_cycle.sv
// MEM stage: data-memory load/store over a req/ack handshake plus the MEM/WB register.
// Optional misaligned-access trapping is enabled by defining MEM_MISALIGN_CHK_EN.
module memory_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALUResult_M,
    input  logic [31:0] WriteData_M,
    input  logic [31:0] PCPlus4_M,
    input  logic [4:0]  RD_M,
    input  logic [2:0]  funct3_M,
    input  logic        mem_rden_M,
    input  logic        mem_wren_M,
    input  logic        rd_wren_M,
    input  logic [1:0]  wb_sel_M,
    input  logic        insn_vld_M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_M,
    output logic        misalign_M,
    output logic [31:0] ReadData_W,
    output logic [31:0] ALUResult_W,
    output logic [31:0] PCPlus4_W,
    output logic [4:0]  RD_W,
    output logic        rd_wren_W,
    output logic [1:0]  wb_sel_W,
    output logic        insn_vld_W
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_nxt;
    logic        mem_op;
    logic        req_en;
    logic [1:0]  off;

    // size field: 00 byte, 01 half, anything else is a word
    function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b00:   byte_en = 4'b0001 << a;
            2'b01:   byte_en = 4'b0011 << {a[1], 1'b0};
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_rep(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   lane_rep = {4{d[7:0]}};
            2'b01:   lane_rep = {2{d[15:0]}};
            default: lane_rep = d;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] d);
        logic [31:0] sb;
        logic [31:0] sh;
        sb = d >> {a, 3'b000};
        sh = d >> {a[1], 4'b0000};
        case (f3[1:0])
            2'b00:   load_ext = f3[2] ? {24'd0, sb[7:0]}  : {{24{sb[7]}}, sb[7:0]};
            2'b01:   load_ext = f3[2] ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: load_ext = d;
        endcase
    endfunction

    assign off = ALUResult_M[1:0];

`ifdef MEM_MISALIGN_CHK_EN
    assign misalign_M = insn_vld_M & (mem_rden_M | mem_wren_M) &
                        (((funct3_M[1:0] == 2'b01) & off[0]) | (funct3_M[1] & (off != 2'b00)));
`else
    assign misalign_M = 1'b0;
`endif

    assign mem_op = insn_vld_M & (mem_rden_M | mem_wren_M) & ~misalign_M;
    // reset forces the bus and stall quiet even if upstream still presents an access
    assign req_en = mem_op & ~rst;

    assign stall_M    = req_en & ~dmem_ack;
    assign dmem_we    = req_en & mem_wren_M;
    assign dmem_addr  = {ALUResult_M[31:2], 2'b00};
    assign dmem_be    = req_en ? byte_en(funct3_M[1:0], off) : 4'b0000;
    assign dmem_wdata = lane_rep(funct3_M[1:0], WriteData_M);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        dmem_req  = 1'b0;
        case (state)
            IDLE: begin
                if (req_en) begin
                    dmem_req = 1'b1;
                    if (!dmem_ack) state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (req_en) begin
                    dmem_req = 1'b1;
                    if (dmem_ack) state_nxt = IDLE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // MEM/WB boundary: a stall inserts a bubble so writeback never commits twice
    always_ff @(posedge clk) begin
        if (rst) begin
            ReadData_W  <= '0;
            ALUResult_W <= '0;
            PCPlus4_W   <= '0;
            RD_W        <= '0;
            rd_wren_W   <= 1'b0;
            wb_sel_W    <= '0;
            insn_vld_W  <= 1'b0;
        end else if (stall_M) begin
            rd_wren_W   <= 1'b0;
            insn_vld_W  <= 1'b0;
        end else begin
            ReadData_W  <= (mem_op & mem_rden_M) ? load_ext(funct3_M, off, dmem_rdata) : 32'd0;
            ALUResult_W <= ALUResult_M;
            PCPlus4_W   <= PCPlus4_M;
            RD_W        <= RD_M;
            rd_wren_W   <= rd_wren_M & insn_vld_M & ~misalign_M;
            wb_sel_W    <= wb_sel_M;
            insn_vld_W  <= insn_vld_M & ~misalign_M;
        end
    end
endmodule

// File: tb/tb_memory_cycle.sv
// Randomized self-checking bench for memory_cycle against a behavioural access model.
module tb_memory_cycle;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALUResult_M, WriteData_M, PCPlus4_M;
    logic [4:0]  RD_M;
    logic [2:0]  funct3_M;
    logic        mem_rden_M, mem_wren_M, rd_wren_M, insn_vld_M;
    logic [1:0]  wb_sel_M;
    logic        dmem_req, dmem_we, dmem_ack, stall_M, misalign_M;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [31:0] ReadData_W, ALUResult_W, PCPlus4_W;
    logic [4:0]  RD_W;
    logic        rd_wren_W, insn_vld_W;
    logic [1:0]  wb_sel_W;

    int total = 0;
    int bad   = 0;

    memory_cycle dut (
        .clk(clk), .rst(rst),
        .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M), .PCPlus4_M(PCPlus4_M),
        .RD_M(RD_M), .funct3_M(funct3_M), .mem_rden_M(mem_rden_M), .mem_wren_M(mem_wren_M),
        .rd_wren_M(rd_wren_M), .wb_sel_M(wb_sel_M), .insn_vld_M(insn_vld_M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall_M(stall_M), .misalign_M(misalign_M),
        .ReadData_W(ReadData_W), .ALUResult_W(ALUResult_W), .PCPlus4_W(PCPlus4_W),
        .RD_W(RD_W), .rd_wren_W(rd_wren_W), .wb_sel_W(wb_sel_W), .insn_vld_W(insn_vld_W)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // access size in bytes
    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int lane_off(input logic [2:0] f3, input logic [31:0] a);
        int sz = acc_size(f3);
        return (int'(a % 4) / sz) * sz;
    endfunction

    function automatic logic [31:0] size_mask(input int sz);
        return (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    endfunction

    function automatic logic exp_misalign(input logic vld, input logic acc, input logic [2:0] f3,
                                          input logic [31:0] a);
`ifdef MEM_MISALIGN_CHK_EN
        return vld && acc && (int'(a % acc_size(f3)) != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        int sz = acc_size(f3);
        return ((32'd1 << sz) - 32'd1) << lane_off(f3, a);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        int sz = acc_size(f3);
        logic [31:0] lane = d & size_mask(sz);
        logic [31:0] r = 32'd0;
        for (int i = 0; i < 4 / sz; i++) r |= lane << (8 * sz * i);
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] d);
        int sz = acc_size(f3);
        logic [31:0] m = size_mask(sz);
        logic [31:0] v = (d >> (8 * lane_off(f3, a))) & m;
        if (sz < 4 && !f3[2] && ((v >> (8 * sz - 1)) & 32'd1) == 32'd1) v |= ~m;
        return v;
    endfunction

    // Presents one instruction at a falling edge, acks after n cycles, checks MEM/WB.
    task automatic run_insn(input logic vld, input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                            input logic rdw, input logic [1:0] wbs, input int n_in,
                            input logic [31:0] rdata);
        logic mis, op;
        logic [31:0] pc;
        int n;
        mis = exp_misalign(vld, ld | st, f3, a);
        op  = vld & (ld | st) & ~mis;
        n   = op ? n_in : 0;
        pc  = $urandom;
        insn_vld_M = vld; mem_rden_M = ld; mem_wren_M = st; funct3_M = f3;
        ALUResult_M = a; WriteData_M = wd; RD_M = rd; rd_wren_M = rdw; wb_sel_M = wbs;
        PCPlus4_M = pc;
        for (int k = 0; k <= n; k++) begin
            dmem_ack   = op ? (k == n) : 1'($urandom_range(0, 1));
            dmem_rdata = (k == n) ? rdata : $urandom;
            #1;
            check("req", {31'd0, dmem_req}, {31'd0, op});
            check("stall", {31'd0, stall_M}, {31'd0, op && (k != n)});
            check("misalign", {31'd0, misalign_M}, {31'd0, mis});
            check("we", {31'd0, dmem_we}, {31'd0, op & st});
            check("be", {28'd0, dmem_be}, op ? exp_be(f3, a) : 32'd0);
            if (op) check("addr", dmem_addr, a & 32'hFFFF_FFFC);
            if (op && st) check("wdata", dmem_wdata, exp_wdata(f3, wd));
            @(posedge clk); #1;
            if (k != n) begin
                check("bubble_vld", {31'd0, insn_vld_W}, 32'd0);
                check("bubble_rdw", {31'd0, rd_wren_W}, 32'd0);
            end else begin
                check("vld_W", {31'd0, insn_vld_W}, {31'd0, vld & ~mis});
                check("rdw_W", {31'd0, rd_wren_W}, {31'd0, rdw & vld & ~mis});
                check("alu_W", ALUResult_W, a);
                check("pc_W", PCPlus4_W, pc);
                check("rd_W", {27'd0, RD_W}, {27'd0, rd});
                check("wbsel_W", {30'd0, wb_sel_W}, {30'd0, wbs});
                check("rdata_W", ReadData_W, (op && ld) ? exp_load(f3, a, rdata) : 32'd0);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        insn_vld_M = 1'b1; mem_rden_M = 1'b1; mem_wren_M = 1'b0; funct3_M = 3'b010;
        ALUResult_M = 32'h40; WriteData_M = 32'h0; PCPlus4_M = 32'h4; RD_M = 5'd1;
        rd_wren_M = 1'b1; wb_sel_M = 2'd1; dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_stall", {31'd0, stall_M}, 32'd0);
        check("rst_be", {28'd0, dmem_be}, 32'd0);
        check("rst_we", {31'd0, dmem_we}, 32'd0);
        check("rst_vld_W", {31'd0, insn_vld_W}, 32'd0);
        check("rst_rdw_W", {31'd0, rd_wren_W}, 32'd0);
        check("rst_data_W", ReadData_W | ALUResult_W | PCPlus4_W, 32'd0);
        check("rst_misc_W", {25'd0, RD_W, wb_sel_W}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // directed cases
        run_insn(1, 0, 0, 3'b000, 32'h1234, 32'h0, 5'd5, 1, 2'd0, 0, 32'h0);
        run_insn(1, 1, 0, 3'b000, 32'h103, 32'h0, 5'd6, 1, 2'd1, 3, 32'h80FF_0000);
        run_insn(1, 1, 0, 3'b100, 32'h103, 32'h0, 5'd7, 1, 2'd1, 3, 32'h80FF_0000);
        run_insn(1, 0, 1, 3'b001, 32'h202, 32'hAAAA_BEEF, 5'd0, 0, 2'd0, 0, 32'h0);
        run_insn(1, 1, 0, 3'b010, 32'h102, 32'h0, 5'd8, 1, 2'd1, 1, 32'hCAFE_F00D);
        run_insn(0, 1, 0, 3'b010, 32'h100, 32'h0, 5'd9, 1, 2'd1, 2, 32'h1);

        // reset while an access is outstanding, then a late ack
        insn_vld_M = 1'b1; mem_rden_M = 1'b1; mem_wren_M = 1'b0; funct3_M = 3'b000;
        ALUResult_M = 32'h40; dmem_ack = 1'b0;
        #1;
        check("busy_req", {31'd0, dmem_req}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstbusy_req", {31'd0, dmem_req}, 32'd0);
        check("rstbusy_stall", {31'd0, stall_M}, 32'd0);
        @(negedge clk);
        rst = 1'b0; insn_vld_M = 1'b0; dmem_ack = 1'b1;
        #1;
        check("late_ack_req", {31'd0, dmem_req}, 32'd0);
        check("late_ack_stall", {31'd0, stall_M}, 32'd0);
        @(posedge clk); #1;
        check("late_ack_vld_W", {31'd0, insn_vld_W}, 32'd0);
        @(negedge clk);
        run_insn(1, 1, 0, 3'b010, 32'h10, 32'h0, 5'd3, 1, 2'd1, 0, 32'h1234_5678);

        // randomized mix, presented back to back
        for (int i = 0; i < 300; i++) begin
            int kind;
            logic [2:0] f3;
            kind = $urandom_range(0, 2);
            f3   = 3'($urandom_range(0, 7));
            run_insn(1'($urandom_range(0, 7) != 0), kind == 1, kind == 2, f3, $urandom, $urandom,
                     5'($urandom), 1'($urandom), 2'($urandom), $urandom_range(0, 4), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
